// File: rtl/vga_pattern_generator.sv
// VGA sync timing and test-pattern generator; sync, colour and frameStart leave in the same register stage.
// Define VGA_PATTERN_ANIMATE_EN to scroll modes 0 and 2 diagonally by one pixel per frame.
module vga_pattern_generator #(
  parameter int H_VISIBLE  = 640,
  parameter int H_FRONT    = 16,
  parameter int H_SYNC     = 96,
  parameter int H_BACK     = 48,
  parameter int V_VISIBLE  = 480,
  parameter int V_FRONT    = 10,
  parameter int V_SYNC     = 2,
  parameter int V_BACK     = 33,
  parameter int COLOR_BITS = 4,
  parameter int BAR_WIDTH  = 80
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [1:0]            mode,
  output logic                  _hSync,
  output logic                  _vSync,
  output logic [COLOR_BITS-1:0] r,
  output logic [COLOR_BITS-1:0] g,
  output logic [COLOR_BITS-1:0] b,
  output logic                  frameStart,
  output logic [10:0]           x,
  output logic [10:0]           y
);

  localparam int H_TOTAL = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
  localparam int V_TOTAL = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;

  localparam logic [10:0] H_LAST     = 11'(H_TOTAL - 1);
  localparam logic [10:0] V_LAST     = 11'(V_TOTAL - 1);
  localparam logic [10:0] H_VIS      = 11'(H_VISIBLE);
  localparam logic [10:0] V_VIS      = 11'(V_VISIBLE);
  localparam logic [10:0] H_VIS_LAST = 11'(H_VISIBLE - 1);
  localparam logic [10:0] V_VIS_LAST = 11'(V_VISIBLE - 1);
  localparam logic [10:0] HS_START   = 11'(H_VISIBLE + H_FRONT);
  localparam logic [10:0] HS_END     = 11'(H_VISIBLE + H_FRONT + H_SYNC - 1);
  localparam logic [10:0] VS_START   = 11'(V_VISIBLE + V_FRONT);
  localparam logic [10:0] VS_END     = 11'(V_VISIBLE + V_FRONT + V_SYNC - 1);
  localparam logic [10:0] BAR_LAST   = 11'(BAR_WIDTH - 1);
  localparam logic [COLOR_BITS-1:0] FULL = '1;

  logic [10:0]           h_count;
  logic [10:0]           v_count;
  logic [10:0]           bar_pix;
  logic [2:0]            bar_idx;
  logic [1:0]            active_mode;
  logic [10:0]           px;
  logic [10:0]           py;
  logic                  visible;
  logic                  h_wrap;
  logic                  frame_wrap;
  logic [COLOR_BITS-1:0] r_next;
  logic [COLOR_BITS-1:0] g_next;
  logic [COLOR_BITS-1:0] b_next;

  assign h_wrap     = (h_count == H_LAST);
  assign frame_wrap = h_wrap && (v_count == V_LAST);
  assign visible    = (h_count < H_VIS) && (v_count < V_VIS);
  assign x          = h_count;
  assign y          = v_count;

  always_ff @(posedge clk) begin
    if (reset) begin
      h_count <= '0;
      v_count <= '0;
    end else if (h_wrap) begin
      h_count <= '0;
      v_count <= (v_count == V_LAST) ? 11'd0 : v_count + 11'd1;
    end else begin
      h_count <= h_count + 11'd1;
    end
  end

  // Bar state tracks the pixel currently on h_count, so it is zeroed as the line wraps into hCount==0.
  always_ff @(posedge clk) begin
    if (reset || h_wrap) begin
      bar_pix <= '0;
      bar_idx <= '0;
    end else if (h_count < H_VIS) begin
      if (bar_pix == BAR_LAST) begin
        bar_pix <= '0;
        if (bar_idx != 3'd7) bar_idx <= bar_idx + 3'd1;
      end else begin
        bar_pix <= bar_pix + 11'd1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset)           active_mode <= 2'd0;
    else if (frame_wrap) active_mode <= mode;
  end

`ifdef VGA_PATTERN_ANIMATE_EN
  logic [7:0] frame_count;

  always_ff @(posedge clk) begin
    if (reset)           frame_count <= '0;
    else if (frame_wrap) frame_count <= frame_count + 8'd1;
  end

  assign px = h_count + {3'b000, frame_count};
  assign py = v_count + {3'b000, frame_count};
`else
  assign px = h_count;
  assign py = v_count;
`endif

  always_comb begin
    r_next = '0;
    g_next = '0;
    b_next = '0;
    if (visible) begin
      case (active_mode)
        2'd0: begin
          r_next = COLOR_BITS'(px);
          g_next = COLOR_BITS'(py >> 2);
        end
        2'd1: begin
          r_next = bar_idx[0] ? FULL : '0;
          g_next = bar_idx[1] ? FULL : '0;
          b_next = bar_idx[2] ? FULL : '0;
        end
        2'd2: begin
          if (|((px ^ py) & 11'h020)) begin
            r_next = FULL;
            g_next = FULL;
            b_next = FULL;
          end
        end
        default: begin
          if (h_count == 11'd0 || h_count == H_VIS_LAST ||
              v_count == 11'd0 || v_count == V_VIS_LAST) begin
            r_next = FULL;
            g_next = FULL;
            b_next = FULL;
          end
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r          <= '0;
      g          <= '0;
      b          <= '0;
      _hSync     <= 1'b1;
      _vSync     <= 1'b1;
      frameStart <= 1'b0;
    end else begin
      r          <= r_next;
      g          <= g_next;
      b          <= b_next;
      _hSync     <= !((h_count >= HS_START) && (h_count <= HS_END));
      _vSync     <= !((v_count >= VS_START) && (v_count <= VS_END));
      frameStart <= (h_count == 11'd0) && (v_count == 11'd0);
    end
  end

endmodule
